// File: rtl/video_argmax_colorize.sv
`timescale 1ns/1ps
// Colourises a per-pixel argmax stream through a run-time palette and alpha-blends it over grey.
// Define VIDEO_ARGMAX_COLORIZE_HIST_EN to build the per-frame class histogram.
module video_argmax_colorize #(
    parameter int CLASS_NUM    = 11,
    parameter int ARGMAX_WIDTH = 8,
    parameter int TDATA_WIDTH  = 10,
    parameter int TUSER_WIDTH  = 1,
    parameter int ALPHA_WIDTH  = 9,
    parameter int HIST_WIDTH   = 24
) (
    input  logic                            aresetn,
    input  logic                            aclk,
    input  logic [TUSER_WIDTH-1:0]          s_axi4s_tuser,
    input  logic                            s_axi4s_tlast,
    input  logic [TDATA_WIDTH-1:0]          s_axi4s_tdata,
    input  logic [ARGMAX_WIDTH-1:0]         s_axi4s_targmax,
    input  logic                            s_axi4s_tvalid,
    output logic                            s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]          m_axi4s_tuser,
    output logic                            m_axi4s_tlast,
    output logic [3*TDATA_WIDTH-1:0]        m_axi4s_tdata,
    output logic                            m_axi4s_tvalid,
    input  logic                            m_axi4s_tready,
    input  logic [ALPHA_WIDTH-1:0]          param_alpha,
    input  logic                            palette_we,
    input  logic [ARGMAX_WIDTH-1:0]         palette_addr,
    input  logic [3*TDATA_WIDTH-1:0]        palette_data,
    output logic [CLASS_NUM*HIST_WIDTH-1:0] m_hist,
    output logic                            m_hist_valid
);
    localparam int CW = 3 * TDATA_WIDTH;
    localparam int BW = TDATA_WIDTH + 9;

    logic                   cke_s;
    logic                   accept_s;
    logic                   in_range_s;
    logic [CW-1:0]          pal_s;
    logic [8:0]             alpha_s;
    logic [CW-1:0]          blend_s;
    logic [CW-1:0]          palette_r [CLASS_NUM];

    logic                   s1_valid_r;
    logic [TUSER_WIDTH-1:0] s1_user_r;
    logic                   s1_last_r;
    logic [TDATA_WIDTH-1:0] s1_grey_r;
    logic [CW-1:0]          s1_pal_r;
    logic [8:0]             s1_alpha_r;

    logic                   out_valid_r;
    logic [TUSER_WIDTH-1:0] out_user_r;
    logic                   out_last_r;
    logic [CW-1:0]          out_data_r;

    // One channel of (grey*(256-a) + pal*a) >> 8 with a in 0..256.
    function automatic logic [TDATA_WIDTH-1:0] blend_ch(
        input logic [TDATA_WIDTH-1:0] grey,
        input logic [TDATA_WIDTH-1:0] pal,
        input logic [8:0]             a
    );
        logic [BW-1:0] sum;
        sum = BW'(grey) * BW'(9'd256 - a) + BW'(pal) * BW'(a);
        return sum[TDATA_WIDTH+7:8];
    endfunction

    assign cke_s          = m_axi4s_tready || !m_axi4s_tvalid;
    assign s_axi4s_tready = cke_s;
    assign accept_s       = s_axi4s_tvalid && cke_s;
    assign in_range_s     = s_axi4s_targmax < ARGMAX_WIDTH'(CLASS_NUM);

    assign m_axi4s_tvalid = out_valid_r;
    assign m_axi4s_tuser  = out_user_r;
    assign m_axi4s_tlast  = out_last_r;
    assign m_axi4s_tdata  = out_data_r;

    // Palette read: OR of the single matching entry, zero for out-of-range indices.
    always_comb begin
        pal_s = '0;
        for (int i = 0; i < CLASS_NUM; i++) begin
            pal_s = pal_s | ((s_axi4s_targmax == ARGMAX_WIDTH'(i)) ? palette_r[i] : {CW{1'b0}});
        end
    end

    // Blend factor: clamped to 256; forced to 0 so invalid classes pass grey through.
    always_comb begin
        if (!in_range_s) begin
            alpha_s = 9'd0;
        end else if (param_alpha > ALPHA_WIDTH'(9'd256)) begin
            alpha_s = 9'd256;
        end else begin
            alpha_s = param_alpha[8:0];
        end
    end

    // Per-channel blend of the stage-1 registers.
    always_comb begin
        blend_s = '0;
        for (int c = 0; c < 3; c++) begin
            blend_s[c*TDATA_WIDTH +: TDATA_WIDTH] =
                blend_ch(s1_grey_r, s1_pal_r[c*TDATA_WIDTH +: TDATA_WIDTH], s1_alpha_r);
        end
    end

    // Palette storage; writes ignore cke and out-of-range addresses never match an entry.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < CLASS_NUM; i++) begin
                palette_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CLASS_NUM; i++) begin
                if (palette_we && (palette_addr == ARGMAX_WIDTH'(i))) begin
                    palette_r[i] <= palette_data;
                end
            end
        end
    end

    // Stage 1: lookup result, grey, effective alpha and sideband.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_r <= 1'b0;
            s1_user_r  <= '0;
            s1_last_r  <= 1'b0;
            s1_grey_r  <= '0;
            s1_pal_r   <= '0;
            s1_alpha_r <= 9'd0;
        end else if (cke_s) begin
            s1_valid_r <= s_axi4s_tvalid;
            s1_user_r  <= s_axi4s_tuser;
            s1_last_r  <= s_axi4s_tlast;
            s1_grey_r  <= s_axi4s_tdata;
            s1_pal_r   <= pal_s;
            s1_alpha_r <= alpha_s;
        end
    end

    // Stage 2: blended output beat, held while the sink stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_r <= 1'b0;
            out_user_r  <= '0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
        end else if (cke_s) begin
            out_valid_r <= s1_valid_r;
            out_user_r  <= s1_user_r;
            out_last_r  <= s1_last_r;
            out_data_r  <= blend_s;
        end
    end

`ifdef VIDEO_ARGMAX_COLORIZE_HIST_EN
    logic [HIST_WIDTH-1:0]           cnt_r [CLASS_NUM];
    logic                            seen_r;
    logic [CLASS_NUM*HIST_WIDTH-1:0] hist_r;
    logic                            hist_valid_r;

    assign m_hist       = hist_r;
    assign m_hist_valid = hist_valid_r;

    // Histogram: counting starts at the first start-of-frame; each later one snapshots and restarts.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < CLASS_NUM; i++) begin
                cnt_r[i] <= '0;
            end
            seen_r       <= 1'b0;
            hist_r       <= '0;
            hist_valid_r <= 1'b0;
        end else begin
            hist_valid_r <= 1'b0;
            if (accept_s && s_axi4s_tuser[0]) begin
                seen_r <= 1'b1;
                if (seen_r) begin
                    for (int i = 0; i < CLASS_NUM; i++) begin
                        hist_r[i*HIST_WIDTH +: HIST_WIDTH] <= cnt_r[i];
                    end
                    hist_valid_r <= 1'b1;
                end
                for (int i = 0; i < CLASS_NUM; i++) begin
                    cnt_r[i] <= (s_axi4s_targmax == ARGMAX_WIDTH'(i)) ? HIST_WIDTH'(1'b1) : '0;
                end
            end else if (accept_s && seen_r) begin
                for (int i = 0; i < CLASS_NUM; i++) begin
                    if ((s_axi4s_targmax == ARGMAX_WIDTH'(i)) && (cnt_r[i] != {HIST_WIDTH{1'b1}})) begin
                        cnt_r[i] <= cnt_r[i] + HIST_WIDTH'(1'b1);
                    end
                end
            end
        end
    end
`else
    assign m_hist       = '0;
    assign m_hist_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_argmax_colorize.sv
`timescale 1ns/1ps
// Randomised bench for video_argmax_colorize: behavioural model with per-cycle compare plus literal pins.
module tb_video_argmax_colorize;
    localparam int CN = 11;
    localparam int HW = 24;
    localparam int HB = CN * HW;

    logic          aresetn = 1'b0;
    logic          aclk = 1'b0;
    logic [0:0]    s_axi4s_tuser = 1'b0;
    logic          s_axi4s_tlast = 1'b0;
    logic [9:0]    s_axi4s_tdata = 10'd0;
    logic [7:0]    s_axi4s_targmax = 8'd0;
    logic          s_axi4s_tvalid = 1'b0;
    logic          s_axi4s_tready;
    logic [0:0]    m_axi4s_tuser;
    logic          m_axi4s_tlast;
    logic [29:0]   m_axi4s_tdata;
    logic          m_axi4s_tvalid;
    logic          m_axi4s_tready = 1'b1;
    logic [8:0]    param_alpha = 9'd0;
    logic          palette_we = 1'b0;
    logic [7:0]    palette_addr = 8'd0;
    logic [29:0]   palette_data = 30'd0;
    logic [HB-1:0] m_hist;
    logic          m_hist_valid;

    video_argmax_colorize dut (
        .aresetn(aresetn), .aclk(aclk),
        .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
        .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_targmax(s_axi4s_targmax),
        .s_axi4s_tvalid(s_axi4s_tvalid), .s_axi4s_tready(s_axi4s_tready),
        .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
        .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
        .m_axi4s_tready(m_axi4s_tready), .param_alpha(param_alpha),
        .palette_we(palette_we), .palette_addr(palette_addr), .palette_data(palette_data),
        .m_hist(m_hist), .m_hist_valid(m_hist_valid)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_ready  = 1'b0;
    bit ready_level = 1'b1;

    task automatic check(input string name, input logic [HB-1:0] act, input logic [HB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected RGB straight from the blend rule, in integer arithmetic.
    function automatic logic [29:0] model_rgb(input logic [9:0] g, input logic [7:0] idx,
                                              input logic [8:0] alpha, input logic [29:0] pal);
        int a;
        int r;
        logic [29:0] res;
        if (int'(idx) >= CN) return {g, g, g};
        a = (int'(alpha) > 256) ? 256 : int'(alpha);
        for (int c = 0; c < 3; c++) begin
            r = (int'(g) * (256 - a) + int'(pal[c*10 +: 10]) * a) / 256;
            res[c*10 +: 10] = r[9:0];
        end
        return res;
    endfunction

    // Sink readiness: random 30% duty when enabled, otherwise a fixed level.
    always @(posedge aclk) begin
        #1;
        m_axi4s_tready = rand_ready ? ($urandom_range(0, 99) < 30) : ready_level;
    end

    logic [31:0]   exp_q[$];
    logic [29:0]   pal_m [CN];
    int            cnt_m [CN];
    logic [HB-1:0] hist_m;
    bit            seen_m, pulse_m, hold_m;
    logic [31:0]   held_m;
    logic [31:0]   beat_s, exp_beat;
    logic [29:0]   lk;

    // Reference model and compare process, evaluated mid-cycle.
    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            for (int i = 0; i < CN; i++) begin pal_m[i] = 30'd0; cnt_m[i] = 0; end
            hist_m = '0; seen_m = 1'b0; pulse_m = 1'b0; hold_m = 1'b0;
        end else begin
            check("hist_valid", m_hist_valid, pulse_m);
            check("hist_value", m_hist, hist_m);
            pulse_m = 1'b0;
            beat_s = {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata};
            if (hold_m) check("hold_stable", {m_axi4s_tvalid, beat_s}, {1'b1, held_m});
            if (m_axi4s_tvalid && m_axi4s_tready) begin
                hold_m = 1'b0;
                check("beat_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    exp_beat = exp_q.pop_front();
                    check("out_beat", beat_s, exp_beat);
                end
            end else if (m_axi4s_tvalid) begin
                hold_m = 1'b1;
                held_m = beat_s;
            end else begin
                hold_m = 1'b0;
            end
            if (s_axi4s_tvalid && s_axi4s_tready) begin
                lk = (int'(s_axi4s_targmax) < CN) ? pal_m[int'(s_axi4s_targmax)] : 30'd0;
                exp_q.push_back({s_axi4s_tuser, s_axi4s_tlast,
                                 model_rgb(s_axi4s_tdata, s_axi4s_targmax, param_alpha, lk)});
`ifdef VIDEO_ARGMAX_COLORIZE_HIST_EN
                if (s_axi4s_tuser[0]) begin
                    if (seen_m) begin
                        for (int i = 0; i < CN; i++) hist_m[i*HW +: HW] = HW'(cnt_m[i]);
                        pulse_m = 1'b1;
                    end
                    for (int i = 0; i < CN; i++) cnt_m[i] = 0;
                    if (int'(s_axi4s_targmax) < CN) cnt_m[int'(s_axi4s_targmax)] = 1;
                    seen_m = 1'b1;
                end else if (seen_m && int'(s_axi4s_targmax) < CN) begin
                    cnt_m[int'(s_axi4s_targmax)]++;
                end
`endif
            end
            if (palette_we && int'(palette_addr) < CN) pal_m[int'(palette_addr)] = palette_data;
        end
    end

    task automatic drive_beat(input logic u, input logic l, input logic [9:0] d, input logic [7:0] arg);
        bit acc = 1'b0;
        int k = 0;
        s_axi4s_tuser = u; s_axi4s_tlast = l; s_axi4s_tdata = d; s_axi4s_targmax = arg;
        s_axi4s_tvalid = 1'b1;
        while (!acc && k < 200) begin
            @(negedge aclk);
            acc = s_axi4s_tready;
            @(posedge aclk);
            #1;
            k++;
        end
        check("accept_in_time", acc, 1'b1);
    endtask

    // Isolated beat: not visible one cycle after accept, visible with exp after two.
    task automatic expect2(input string name, input logic [31:0] exp);
        @(negedge aclk);
        check({name, "_early"}, m_axi4s_tvalid, 1'b0);
        @(posedge aclk);
        @(negedge aclk);
        check(name, {m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}, {1'b1, exp});
        @(posedge aclk);
        #1;
    endtask

    task automatic pal_write(input logic [7:0] addr, input logic [29:0] data);
        palette_we = 1'b1; palette_addr = addr; palette_data = data;
        @(posedge aclk);
        #1;
        palette_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [HB-1:0] exp_h;
        int k;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_state", {m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata, m_hist_valid},
              33'd0);
        check("reset_hist", m_hist, '0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Grey passthrough with sideband alignment.
        param_alpha = 9'd0;
        drive_beat(1'b1, 1'b1, 10'd300, 8'd2);
        s_axi4s_tvalid = 1'b0;
        expect2("grey_pass", {1'b1, 1'b1, 10'd300, 10'd300, 10'd300});

        // Blend and alpha clamp.
        pal_write(8'd3, {10'd0, 10'd0, 10'd1023});
        param_alpha = 9'd128;
        drive_beat(1'b0, 1'b0, 10'd512, 8'd3);
        s_axi4s_tvalid = 1'b0;
        expect2("blend_128", {2'b00, 10'd256, 10'd256, 10'd767});
        param_alpha = 9'd300;
        drive_beat(1'b0, 1'b0, 10'd512, 8'd3);
        s_axi4s_tvalid = 1'b0;
        expect2("blend_clamp", {2'b00, 10'd0, 10'd0, 10'd1023});

        // Out-of-range index passes grey at full alpha.
        param_alpha = 9'd256;
        drive_beat(1'b0, 1'b0, 10'd77, 8'd11);
        s_axi4s_tvalid = 1'b0;
        expect2("out_of_range", {2'b00, 10'd77, 10'd77, 10'd77});

        // Palette write colliding with a lookup of the same entry.
        pal_write(8'd5, {10'd1, 10'd2, 10'd3});
        palette_we = 1'b1; palette_addr = 8'd5; palette_data = {10'd900, 10'd800, 10'd700};
        drive_beat(1'b0, 1'b0, 10'd0, 8'd5);
        palette_we = 1'b0;
        s_axi4s_tvalid = 1'b0;
        expect2("pal_hazard_old", {2'b00, 10'd1, 10'd2, 10'd3});
        drive_beat(1'b0, 1'b0, 10'd0, 8'd5);
        s_axi4s_tvalid = 1'b0;
        expect2("pal_hazard_new", {2'b00, 10'd900, 10'd800, 10'd700});

        // 4x4 histogram frame, then the start of the next frame.
        for (int i = 0; i < 16; i++) begin
            drive_beat(i == 0, (i % 4) == 3, 10'(i * 7), (i < 10) ? 8'd0 : ((i < 15) ? 8'd7 : 8'd200));
        end
        drive_beat(1'b1, 1'b0, 10'd5, 8'd1);
        s_axi4s_tvalid = 1'b0;
        @(negedge aclk);
`ifdef VIDEO_ARGMAX_COLORIZE_HIST_EN
        exp_h = '0;
        exp_h[0 +: HW] = 24'd10;
        exp_h[7*HW +: HW] = 24'd5;
        check("hist_pulse", m_hist_valid, 1'b1);
        check("hist_frame1", m_hist, exp_h);
`else
        exp_h = '0;
        check("hist_pulse_off", m_hist_valid, 1'b0);
        check("hist_frame1_off", m_hist, exp_h);
`endif
        @(posedge aclk);
        @(negedge aclk);
        check("hist_pulse_once", m_hist_valid, 1'b0);
        @(posedge aclk);
        #1;

        // Random 64x4 frames under 30% sink duty.
        rand_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int y = 0; y < 4; y++) begin
                for (int x = 0; x < 64; x++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        s_axi4s_tvalid = 1'b0;
                        @(posedge aclk);
                        #1;
                    end
                    param_alpha  = 9'($urandom_range(0, 511));
                    palette_we   = ($urandom_range(0, 7) == 0);
                    palette_addr = 8'($urandom_range(0, 15));
                    palette_data = 30'($urandom);
                    drive_beat((x == 0) && (y == 0), x == 63, 10'($urandom),
                               ($urandom_range(0, 9) == 0) ? 8'($urandom_range(11, 255))
                                                           : 8'($urandom_range(0, 10)));
                    palette_we = 1'b0;
                end
            end
        end
        s_axi4s_tvalid = 1'b0;
        rand_ready = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge aclk);
            k++;
        end
        #1;
        check("drain_empty", exp_q.size(), 0);

        // Mid-frame reset with a stalled pipeline.
        ready_level = 1'b0;
        @(posedge aclk);
        #1;
        drive_beat(1'b1, 1'b0, 10'd11, 8'd3);
        drive_beat(1'b0, 1'b0, 10'd22, 8'd3);
        drive_beat_hold: begin
            s_axi4s_tdata = 10'd33;
            s_axi4s_tvalid = 1'b1;
            @(negedge aclk);
            @(posedge aclk);
            #1;
        end
        aresetn = 1'b0;
        @(negedge aclk);
        check("reset_mid_tvalid", m_axi4s_tvalid, 1'b0);
        check("reset_mid_hist", {m_hist_valid, m_hist}, '0);
        s_axi4s_tvalid = 1'b0;
        ready_level = 1'b1;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        param_alpha = 9'd256;
        drive_beat(1'b1, 1'b0, 10'd400, 8'd3);
        s_axi4s_tvalid = 1'b0;
        @(negedge aclk);
        check("no_pulse_after_reset", m_hist_valid, 1'b0);
        @(posedge aclk);
        @(negedge aclk);
        check("palette_cleared", {m_axi4s_tvalid, m_axi4s_tdata}, {1'b1, 30'd0});
        @(posedge aclk);
        #1;
        drive_beat(1'b1, 1'b0, 10'd1, 8'd4);
        s_axi4s_tvalid = 1'b0;
        repeat (4) @(posedge aclk);
        #1;
        check("final_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
